// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the 7-segment bus capture block:
//   SEG_0..SEG_F   active-high segment patterns (gfedcba) for the hex digits
//   cap_state_t    capture FSM states
//   an_class_t     classification of the active-low digit-enable bus
//   an_classify    maps an[3:0] to its class
//   an_to_idx      maps a one-hot-low an[3:0] to the digit index
package sevenseg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_t;

    typedef enum logic [1:0] {
        AN_SELECT,
        AN_BLANK,
        AN_ILLEGAL
    } an_class_t;

    // Exactly one low bit selects a digit; all high is a blanking gap.
    function automatic an_class_t an_classify(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return AN_SELECT;
            4'b1111:                            return AN_BLANK;
            default:                            return AN_ILLEGAL;
        endcase
    endfunction

    // Only meaningful when an_classify() reports AN_SELECT.
    function automatic logic [1:0] an_to_idx(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_pattern_dec.sv
// sevenseg_pattern_dec
// Combinational decoder from an active-low segment pattern back to a hex nibble.
// Ports:
//   seg_n   in   7  segment lines, active-low, bit6=g .. bit0=a
//   hit     out  1  pattern matches one of the 16 hex glyphs
//   nibble  out  4  decoded value (0 when hit is low)
module sevenseg_pattern_dec
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic [3:0] nibble
);

    logic [6:0] seg_on;

    assign seg_on = ~seg_n;

    // Exact match against the glyph table; anything else is a miss.
    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg_on)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
// Reader side of a 4-digit multiplexed 7-segment display bus. Synchronizes the
// bus, waits for each digit to settle, decodes it and rebuilds the displayed
// 16-bit value, tracks complete 0->1->2->3 scans and ages out stale digits.
// Optional feature macro: SEVENSEG_CAP_ERRCNT_EN adds the err_cnt output.
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   seg          in   7   segment lines, active-low, bit6=g .. bit0=a (async)
//   an           in   4   digit enables, active-low one-hot, an[0]=rightmost (async)
//   value        out  16  captured value, digit i in value[4*i+3:4*i]
//   digit_valid  out  4   digit i holds a decoded, non-stale nibble
//   frame_stb    out  1   one-cycle pulse after a full in-order scan
//   err          out  1   sticky: unknown pattern or multi-hot an seen
//   err_cnt      out  8   (SEVENSEG_CAP_ERRCNT_EN only) saturating error count
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_stb,
    output logic        err
`ifdef SEVENSEG_CAP_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    logic [6:0]       seg_s1, seg_s2, seg_prev;
    logic [3:0]       an_s1, an_s2, an_prev;
    cap_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [TMO_W-1:0] idle_cnt;
    logic [1:0]       ptr;
    logic             commit;
    logic             illegal_seen;
    logic             bus_changed;
    an_class_t        an_cls;
    logic [1:0]       idx;
    logic             dec_hit;
    logic [3:0]       dec_nibble;

    assign bus_changed = {an_s2, seg_s2} != {an_prev, seg_prev};
    assign an_cls      = an_classify(an_s2);
    assign idx         = an_to_idx(an_s2);

    sevenseg_pattern_dec u_dec (
        .seg_n  (seg_s2),
        .hit    (dec_hit),
        .nibble (dec_nibble)
    );

    // Two-flop synchronizers plus a copy of the previous synchronized sample,
    // which is what "settled" is judged against. Reset parks everything on a
    // blank bus so no digit can appear to be selected out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1   <= '1;
            seg_s2   <= '1;
            seg_prev <= '1;
            an_s1    <= '1;
            an_s2    <= '1;
            an_prev  <= '1;
            state    <= IDLE;
            cnt      <= '0;
        end else begin
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            an_s1    <= an;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
            state    <= state_next;
            cnt      <= cnt_next;
        end
    end

    // Settle FSM: a newly selected digit starts counting at 1; identical
    // samples count up and the digit commits once when the count reaches
    // STABLE_CYCLES. HOLD blocks repeat commits until the bus moves. With
    // STABLE_CYCLES==1 the first sample already counts as settled.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        commit       = 1'b0;
        illegal_seen = 1'b0;
        case (state)
            IDLE: begin
                if (an_cls == AN_SELECT) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        commit     = 1'b1;
                        state_next = HOLD;
                    end
                end else if (an_cls == AN_ILLEGAL) begin
                    illegal_seen = 1'b1;
                end
            end
            SETTLE, HOLD: begin
                if (bus_changed) begin
                    if (an_cls == AN_SELECT) begin
                        state_next = SETTLE;
                        cnt_next   = CNT_W'(1);
                        if (STABLE_CYCLES == 1) begin
                            commit     = 1'b1;
                            state_next = HOLD;
                        end
                    end else begin
                        state_next   = IDLE;
                        illegal_seen = (an_cls == AN_ILLEGAL);
                    end
                end else if (state == SETTLE) begin
                    if (cnt == CNT_LAST) begin
                        commit     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Commit datapath, in-order scan tracker and staleness timeout. A miss
    // invalidates the digit but leaves its old nibble in place. The idle
    // counter saturates at the timeout so stale digits stay invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            digit_valid <= '0;
            frame_stb   <= 1'b0;
            err         <= 1'b0;
            ptr         <= '0;
            idle_cnt    <= '0;
        end else begin
            frame_stb <= 1'b0;
            if (illegal_seen) begin
                err <= 1'b1;
            end
            if (commit) begin
                idle_cnt <= '0;
                if (dec_hit) begin
                    value[4*idx +: 4] <= dec_nibble;
                    digit_valid[idx]  <= 1'b1;
                    if (idx == ptr) begin
                        if (ptr == 2'd3) begin
                            frame_stb <= 1'b1;
                            ptr       <= 2'd0;
                        end else begin
                            ptr <= ptr + 2'd1;
                        end
                    end else begin
                        ptr <= (idx == 2'd0) ? 2'd1 : 2'd0;
                    end
                end else begin
                    digit_valid[idx] <= 1'b0;
                    err              <= 1'b1;
                    ptr              <= 2'd0;
                end
            end else if (idle_cnt != TMO_MAX) begin
                idle_cnt <= idle_cnt + TMO_W'(1);
            end else begin
                digit_valid <= '0;
                ptr         <= 2'd0;
            end
        end
    end

`ifdef SEVENSEG_CAP_ERRCNT_EN
    // Counts miss commits and transitions onto an illegal enable pattern,
    // so a multi-hot bus that just sits there is counted only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (((commit && !dec_hit) || (illegal_seen && bus_changed))
                     && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture
// Self-checking bench for sevenseg_capture: table of bus vectors with expected
// value/digit_valid/err/frame count, plus hand-written glitch, timeout and
// mid-settle reset sequences. Expectations go through a scoreboard queue.
module tb_sevenseg_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 300;
    localparam int HOLDC  = STABLE + 2;

    localparam logic [6:0] P_0 = 7'b0111111;
    localparam logic [6:0] P_1 = 7'b0000110;
    localparam logic [6:0] P_2 = 7'b1011011;
    localparam logic [6:0] P_3 = 7'b1001111;
    localparam logic [6:0] P_4 = 7'b1100110;
    localparam logic [6:0] P_5 = 7'b1101101;
    localparam logic [6:0] P_6 = 7'b1111101;
    localparam logic [6:0] P_7 = 7'b0000111;
    localparam logic [6:0] P_8 = 7'b1111111;
    localparam logic [6:0] P_9 = 7'b1101111;
    localparam logic [6:0] P_A = 7'b1110111;
    localparam logic [6:0] P_B = 7'b1111100;
    localparam logic [6:0] P_C = 7'b0111001;
    localparam logic [6:0] P_D = 7'b1011110;
    localparam logic [6:0] P_E = 7'b1111001;
    localparam logic [6:0] P_F = 7'b1110001;
    localparam logic [6:0] P_BAD = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_stb;
    logic        err;
`ifdef SEVENSEG_CAP_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    typedef struct {
        bit          rst_before;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        err;
        int          frames;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        err;
        int          frames;
    } exp_t;

    vec_t vecs[26];
    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   frames     = 0;

    always #5 clk = ~clk;

    sevenseg_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_stb   (frame_stb),
        .err         (err)
`ifdef SEVENSEG_CAP_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    // Each frame_stb pulse is a separate rising edge; commits are far apart.
    always @(posedge frame_stb) frames++;

    function automatic vec_t mk(bit r, logic [3:0] a, logic [6:0] p_on, int h,
                                logic [15:0] v, logic [3:0] dv, logic e, int f);
        vec_t t;
        t.rst_before = r;
        t.an         = a;
        t.seg        = ~p_on;
        t.hold       = h;
        t.value      = v;
        t.valid      = dv;
        t.err        = e;
        t.frames     = f;
        return t;
    endfunction

    task automatic cmp(input string what, input int id, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", what, id, act, expv);
        end
    endtask

    task automatic pushExpect(input int id, input logic [15:0] v, input logic [3:0] dv,
                              input logic e, input int f);
        exp_t x;
        x.id     = id;
        x.value  = v;
        x.valid  = dv;
        x.err    = e;
        x.frames = f;
        sbq.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t x;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            x = sbq.pop_front();
            cmp("value", x.id, 32'(value), 32'(x.value));
            cmp("digit_valid", x.id, 32'(digit_valid), 32'(x.valid));
            cmp("err", x.id, 32'(err), 32'(x.err));
            cmp("frame_count", x.id, 32'(frames), 32'(x.frames));
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the hold window.
    task automatic applyStimulus(input int id, input vec_t v);
        an  = v.an;
        seg = v.seg;
        if (v.rst_before) doReset();
        pushExpect(id, v.value, v.valid, v.err, v.frames);
        repeat (v.hold) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runRows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(i, vecs[i]);
            checkOutput();
        end
    endtask

    initial begin
        // Scan 0x1234, in-place digit changes, blanking, all 16 glyphs.
        vecs[0]  = mk(0, 4'b1110, P_4, HOLDC, 16'h0004, 4'b0001, 0, 0);
        vecs[1]  = mk(0, 4'b1101, P_3, HOLDC, 16'h0034, 4'b0011, 0, 0);
        vecs[2]  = mk(0, 4'b1011, P_2, HOLDC, 16'h0234, 4'b0111, 0, 0);
        vecs[3]  = mk(0, 4'b0111, P_1, HOLDC, 16'h1234, 4'b1111, 0, 1);
        vecs[4]  = mk(0, 4'b1110, P_6, HOLDC, 16'h1236, 4'b1111, 0, 1);
        vecs[5]  = mk(0, 4'b1110, P_5, HOLDC, 16'h1235, 4'b1111, 0, 1);
        vecs[6]  = mk(0, 4'b1111, P_8, 8,     16'h1235, 4'b1111, 0, 1);
        vecs[7]  = mk(0, 4'b1101, P_A, HOLDC, 16'h12A5, 4'b1111, 0, 1);
        vecs[8]  = mk(0, 4'b1011, P_B, HOLDC, 16'h1BA5, 4'b1111, 0, 1);
        vecs[9]  = mk(0, 4'b0111, P_F, HOLDC, 16'hFBA5, 4'b1111, 0, 2);
        vecs[10] = mk(0, 4'b1110, P_C, HOLDC, 16'hFBAC, 4'b1111, 0, 2);
        vecs[11] = mk(0, 4'b1101, P_D, HOLDC, 16'hFBDC, 4'b1111, 0, 2);
        vecs[12] = mk(0, 4'b1011, P_E, HOLDC, 16'hFEDC, 4'b1111, 0, 2);
        vecs[13] = mk(0, 4'b0111, P_0, HOLDC, 16'h0EDC, 4'b1111, 0, 3);
        vecs[14] = mk(0, 4'b1110, P_8, HOLDC, 16'h0ED8, 4'b1111, 0, 3);
        vecs[15] = mk(0, 4'b1101, P_9, HOLDC, 16'h0E98, 4'b1111, 0, 3);
        vecs[16] = mk(0, 4'b1011, P_7, HOLDC, 16'h0798, 4'b1111, 0, 3);
        // Finish a frame after the glitch test (digit 0 = 2 by then).
        vecs[17] = mk(0, 4'b1101, P_3, HOLDC, 16'h0732, 4'b1111, 0, 3);
        vecs[18] = mk(0, 4'b1011, P_4, HOLDC, 16'h0432, 4'b1111, 0, 3);
        vecs[19] = mk(0, 4'b0111, P_5, HOLDC, 16'h5432, 4'b1111, 0, 4);
        // Error cases: blank, multi-hot an, unknown glyph on digit 2.
        vecs[20] = mk(0, 4'b1111, P_8, 8,     16'h0000, 4'b0000, 0, 4);
        vecs[21] = mk(0, 4'b1100, P_8, HOLDC, 16'h0000, 4'b0000, 1, 4);
        vecs[22] = mk(1, 4'b1110, P_9, HOLDC, 16'h0009, 4'b0001, 0, 4);
        vecs[23] = mk(0, 4'b1101, P_1, HOLDC, 16'h0019, 4'b0011, 0, 4);
        vecs[24] = mk(0, 4'b1011, P_BAD, HOLDC, 16'h0019, 4'b0011, 1, 4);
        vecs[25] = mk(0, 4'b0111, P_2, HOLDC, 16'h2019, 4'b1011, 1, 4);

        an  = 4'b1111;
        seg = 7'h7F;
        rst = 1'b0;
        @(negedge clk);
        doReset();
        pushExpect(100, 16'h0000, 4'b0000, 0, 0);
        checkOutput();
        cmp("frame_stb_reset", 100, 32'(frame_stb), 32'd0);

        runRows(0, 16);

        // Glitch: digit 0 shows 1 for one sample too few, then 2.
        an  = 4'b1110;
        seg = ~P_1;
        repeat (STABLE - 1) @(posedge clk);
        @(negedge clk);
        seg = ~P_2;
        pushExpect(200, 16'h0798, 4'b1111, 0, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput();
        pushExpect(201, 16'h0792, 4'b1111, 0, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput();

        runRows(17, 19);

        // Blank bus after a full frame: digits go stale, value is kept.
        an  = 4'b1111;
        seg = 7'h7F;
        pushExpect(300, 16'h5432, 4'b1111, 0, 4);
        repeat (TMO - 10) @(posedge clk);
        @(negedge clk);
        checkOutput();
        pushExpect(301, 16'h5432, 4'b0000, 0, 4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput();

        // Reset while digit 0 is mid-settle.
        an  = 4'b1110;
        seg = ~P_7;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pushExpect(400, 16'h0000, 4'b0000, 0, 4);
        checkOutput();
        cmp("frame_stb_midrst", 400, 32'(frame_stb), 32'd0);
        an  = 4'b1111;
        seg = 7'h7F;
        rst = 1'b0;
        pushExpect(401, 16'h0000, 4'b0000, 0, 4);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput();

        runRows(20, 25);

`ifdef SEVENSEG_CAP_ERRCNT_EN
        cmp("err_cnt", 500, 32'(err_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
